// File: rtl/coproc_pkg.sv
// Shared image-coprocessor constants and the row-side state encoding.
package coproc_pkg;
   localparam int PIX_W = 12;
   localparam int COLS  = 256;
   localparam int ROW_W = PIX_W * COLS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      STREAM = 2'd2
   } state_e;

   // Frames longer than the row buffer are clipped to a full buffer.
   function automatic logic [8:0] sat_rows(input logic [8:0] n);
      return (n > 9'd256) ? 9'd256 : n;
   endfunction
endpackage

// File: rtl/row_shift_reg.sv
// Full-row holding register; loads a packed row and shifts one pixel out per step.
module row_shift_reg #(
   parameter int PIX_W = coproc_pkg::PIX_W,
   parameter int ROW_W = coproc_pkg::ROW_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             shift,
   input  logic [ROW_W-1:0] din,
   output logic [PIX_W-1:0] dout
);
   logic [ROW_W-1:0] sr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     sr_q <= '0;
      else if (load)  sr_q <= din;
      else if (shift) sr_q <= {{PIX_W{1'b0}}, sr_q[ROW_W-1:PIX_W]};
   end

   assign dout = sr_q[PIX_W-1:0];
endmodule

// File: rtl/data_disperse.sv
// Row-to-pixel serializer: fetches whole rows and streams them out pixel by pixel.
module data_disperse #(
   parameter int PIX_W = coproc_pkg::PIX_W,
   parameter int COLS  = coproc_pkg::COLS,
   parameter int ROW_W = PIX_W * COLS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [8:0]       num_rows,
   output logic             row_req,
   input  logic             row_vld,
   input  logic [ROW_W-1:0] row_in,
   output logic             pix_vld,
   input  logic             pix_rdy,
   output logic [PIX_W-1:0] pix_out,
   output logic [7:0]       col_cnt,
   output logic [8:0]       row_cnt,
   output logic             row_done,
   output logic             frame_done,
   output logic             busy
);
   import coproc_pkg::*;

   state_e     state_q;
   logic [8:0] nrows_q, row_cnt_q, row_cnt_d;
   logic [7:0] col_cnt_q;
   logic       row_done_q, frame_done_q;
   logic       hs, last_col, load;

   assign hs        = (state_q == STREAM) && pix_rdy;
   assign last_col  = (col_cnt_q == 8'(COLS - 1));
   assign row_cnt_d = row_cnt_q + 9'd1;
   // start overrides both a pending load and a coincident handshake.
   assign load      = !start && (state_q == REQ) && row_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         nrows_q      <= '0;
         row_cnt_q    <= '0;
         col_cnt_q    <= '0;
         row_done_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         row_done_q   <= 1'b0;
         frame_done_q <= 1'b0;
         if (start) begin
            nrows_q   <= sat_rows(num_rows);
            row_cnt_q <= '0;
            col_cnt_q <= '0;
            if (num_rows == 9'd0) begin
               state_q      <= IDLE;
               frame_done_q <= 1'b1;
            end else begin
               state_q <= REQ;
            end
         end else begin
            case (state_q)
               REQ: if (row_vld) begin
                  col_cnt_q <= '0;
                  state_q   <= STREAM;
               end
               STREAM: if (hs) begin
                  if (last_col) begin
                     row_done_q <= 1'b1;
                     row_cnt_q  <= row_cnt_d;
                     if (row_cnt_d == nrows_q) begin
                        state_q      <= IDLE;
                        frame_done_q <= 1'b1;
                     end else begin
                        state_q <= REQ;
                     end
                  end else begin
                     col_cnt_q <= col_cnt_q + 8'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   row_shift_reg #(.PIX_W(PIX_W), .ROW_W(ROW_W)) u_sr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .shift (hs && !start),
      .din   (row_in),
      .dout  (pix_out)
   );

   assign row_req    = (state_q == REQ);
   assign pix_vld    = (state_q == STREAM);
   assign busy       = (state_q != IDLE);
   assign col_cnt    = col_cnt_q;
   assign row_cnt    = row_cnt_q;
   assign row_done   = row_done_q;
   assign frame_done = frame_done_q;
endmodule

// File: tb/tb_data_disperse.sv
// Bench for data_disperse: frame table plus reset / abort sequences, scoreboarded pixels.
module tb_data_disperse;
   import coproc_pkg::*;

   logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [8:0]       num_rows = '0;
   logic             row_req, row_vld = 1'b0, pix_vld, pix_rdy = 1'b0;
   logic [ROW_W-1:0] row_in = '0;
   logic [PIX_W-1:0] pix_out;
   logic [7:0]       col_cnt;
   logic [8:0]       row_cnt;
   logic             row_done, frame_done, busy;

   always #5 clk = ~clk;

   data_disperse dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
      .row_req(row_req), .row_vld(row_vld), .row_in(row_in),
      .pix_vld(pix_vld), .pix_rdy(pix_rdy), .pix_out(pix_out),
      .col_cnt(col_cnt), .row_cnt(row_cnt), .row_done(row_done),
      .frame_done(frame_done), .busy(busy)
   );

   typedef struct {logic [11:0] pix; logic [7:0] col; logic [8:0] row;} exp_t;
   typedef struct {int nrows; int pat; bit rnd; bit inj; int erd; int efd; int erq;} vec_t;

   exp_t sb[$];
   vec_t vt[5];
   int   checks = 0, errors = 0;

   int   pat_g, nrows_g, rows_fed, rd, fd, rq, pvc, nticks;
   bit   rnd_g, inj_g, prev_req, fed_last, hs255_last, hold_pend;
   logic [11:0] hold_pix;
   logic [7:0]  hold_col;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input int act);
      checks++;
      errors++;
      $display("FAIL %s actual=%0d required=bounded", name, act);
   endtask

   // One cycle: observe outputs, drive next inputs, score any handshake.
   task automatic tick();
      bit               rdy;
      logic [ROW_W-1:0] r;
      logic [11:0]      v;
      exp_t             e;
      nticks++;
      if (pix_vld) pvc++;
      if (fed_last) begin
         chk("vld_after_load", 32'(pix_vld), 32'd1);
         chk("req_drop", 32'(row_req), 32'd0);
      end
      if (hold_pend && pix_vld) begin
         chk("hold_pix", 32'(pix_out), 32'(hold_pix));
         chk("hold_col", 32'(col_cnt), 32'(hold_col));
      end
      if (row_done) begin
         rd++;
         chk("rowdone_after_c255", 32'(hs255_last), 32'd1);
      end
      if (frame_done) begin
         fd++;
         if (nrows_g > 0) chk("fd_with_rd", 32'(row_done), 32'd1);
      end
      if (row_req && !prev_req) rq++;
      prev_req = row_req;

      rdy      = rnd_g ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_rdy  = rdy;
      row_vld  = 1'b0;
      fed_last = 1'b0;
      if (row_req) begin
         r = '0;
         for (int c = 0; c < COLS; c++) begin
            case (pat_g)
               0:       v = 12'(c + 1);
               1:       v = 12'(rows_fed);
               default: v = 12'($urandom);
            endcase
            r[c*PIX_W +: PIX_W] = v;
            sb.push_back('{v, 8'(c), 9'(rows_fed)});
         end
         row_in   = r;
         row_vld  = 1'b1;
         rows_fed++;
         fed_last = 1'b1;
      end else if (inj_g) begin
         row_in  = {COLS{12'hABC}};
         row_vld = 1'b1;
      end

      hs255_last = 1'b0;
      if (pix_vld && rdy) begin
         if (sb.size() == 0) fail("sb_underflow", 0);
         else begin
            e = sb.pop_front();
            chk("pix", 32'(pix_out), 32'(e.pix));
            chk("col", 32'(col_cnt), 32'(e.col));
            chk("row", 32'(row_cnt), 32'(e.row));
         end
         hs255_last = (col_cnt == 8'd255);
      end
      hold_pend = pix_vld && !rdy;
      hold_pix  = pix_out;
      hold_col  = col_cnt;
      @(posedge clk); #1;
   endtask

   task automatic reset_tracking(input int nrows, input int pat, input bit rnd, input bit inj);
      nrows_g = nrows; pat_g = pat; rnd_g = rnd; inj_g = inj;
      rows_fed = 0; rd = 0; fd = 0; rq = 0; pvc = 0; nticks = 0;
      prev_req = 0; fed_last = 0; hs255_last = 0; hold_pend = 0;
   endtask

   task automatic pulse_start(input int nrows);
      start = 1'b1; num_rows = 9'(nrows); pix_rdy = 1'b1; row_vld = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_frame(input int nrows, input int pat, input bit rnd, input bit inj,
                            input bit do_start);
      int budget;
      reset_tracking(nrows, pat, rnd, inj);
      if (do_start) begin
         pulse_start(nrows);
         chk("busy_after_start", 32'(busy), 32'(nrows > 0));
         if (nrows > 0) chk("req_t+1", 32'(row_req), 32'd1);
      end
      budget = nrows * 256 * 4 + 20;
      while (fd == 0 && nticks < budget) tick();
      if (fd == 0) fail("frame_timeout", nticks);
      if (nrows == 0) chk("fd0_latency", 32'(nticks), 32'd1);
      if (!rnd) chk("full_rate_vld_cycles", 32'(pvc), 32'(nrows * 256));
      repeat (3) tick();
   endtask

   initial begin
      int n;
      vt[0] = '{1, 0, 0, 0, 1, 1, 1};
      vt[1] = '{3, 1, 0, 0, 3, 1, 3};
      vt[2] = '{2, 2, 1, 0, 2, 1, 2};
      vt[3] = '{0, 0, 0, 0, 0, 1, 0};
      vt[4] = '{1, 2, 1, 1, 1, 1, 1};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req", 32'(row_req), 32'd0);
      chk("rst_vld", 32'(pix_vld), 32'd0);
      chk("rst_cnts", {15'd0, row_cnt, col_cnt}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) begin
         run_frame(vt[i].nrows, vt[i].pat, vt[i].rnd, vt[i].inj, 1'b1);
         chk($sformatf("v%0d_row_done", i), 32'(rd), 32'(vt[i].erd));
         chk($sformatf("v%0d_frame_done", i), 32'(fd), 32'(vt[i].efd));
         chk($sformatf("v%0d_req_phases", i), 32'(rq), 32'(vt[i].erq));
         chk($sformatf("v%0d_sb_empty", i), 32'(sb.size()), 32'd0);
         chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
      end

      // Abort at column 100 of row 1, then let the restarted frame complete.
      reset_tracking(2, 1, 0, 0);
      pulse_start(2);
      n = 0;
      while (!(pix_vld && row_cnt == 9'd1 && col_cnt == 8'd100) && n < 2000) begin
         tick();
         n++;
      end
      if (n >= 2000) fail("abort_reach_timeout", n);
      start = 1'b1; num_rows = 9'd2; pix_rdy = 1'b1; row_vld = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("abort_vld", 32'(pix_vld), 32'd0);
      chk("abort_row_cnt", 32'(row_cnt), 32'd0);
      chk("abort_col_cnt", 32'(col_cnt), 32'd0);
      chk("abort_req", 32'(row_req), 32'd1);
      sb.delete();
      run_frame(2, 0, 0, 0, 1'b0);
      chk("abort_row_done", 32'(rd), 32'd2);
      chk("abort_frame_done", 32'(fd), 32'd1);
      chk("abort_sb_empty", 32'(sb.size()), 32'd0);

      // Asynchronous reset in the middle of a row.
      reset_tracking(1, 0, 0, 0);
      pulse_start(1);
      repeat (40) tick();
      chk("pre_rst_streaming", 32'(pix_vld), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_vld", 32'(pix_vld), 32'd0);
      chk("mid_rst_req", 32'(row_req), 32'd0);
      chk("mid_rst_pix", 32'(pix_out), 32'd0);
      chk("mid_rst_cnts", {15'd0, row_cnt, col_cnt}, 32'd0);
      chk("mid_rst_pulses", {30'd0, row_done, frame_done}, 32'd0);
      sb.delete();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/data_disperse.md
# data_disperse

Row-to-pixel serializer for the image coprocessor, the read-side counterpart of the row accumulator. It requests full 3072-bit rows (256 × 12-bit pixels) from the row buffer and emits them as a stream of one 12-bit pixel per accepted handshake, with a matching column count. It feeds the pixel-processing pipeline and paces itself on downstream backpressure. It walks a programmable number of rows per frame.

## Interface
Parameters:
- PIX_W, 12, pixel width in bits
- COLS, 256, pixels per row
- ROW_W, PIX_W*COLS (3072), packed row width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that begins a frame; also aborts any frame in progress
- num_rows  in  9  rows in the frame (0..256); sampled only on start
- row_req  out  1  high while waiting for the next row
- row_vld  in  1  row_in valid; honoured only while row_req=1
- row_in  in  ROW_W  packed row; column c occupies bits [12c+11:12c]
- pix_vld  out  1  pix_out valid
- pix_rdy  in  1  downstream accepts pix_out when pix_vld & pix_rdy
- pix_out  out  PIX_W  current pixel
- col_cnt  out  8  column index of pix_out
- row_cnt  out  9  index of the row being streamed
- row_done  out  1  one-cycle pulse after the last pixel of a row is accepted
- frame_done  out  1  one-cycle pulse when the frame completes
- busy  out  1  state ≠ IDLE

## Operation
- States:
  - IDLE → REQ on start with num_rows>0.
  - REQ → STREAM on row_vld.
  - STREAM → REQ, or STREAM → IDLE, after column 255 is accepted.
- Reset values: state IDLE; all outputs 0; shift register and counters 0.
- In REQ, row_req=1. A cycle with row_vld=1 loads row_in into the shift register and clears col_cnt.
- In STREAM:
  - pix_vld=1 and pix_out = shift register bits [11:0].
  - On each handshake, the register shifts right by PIX_W and col_cnt increments.
  - pix_out and col_cnt hold stable while pix_rdy=0.
- Handshake on column 255:
  - row_done pulses.
  - row_cnt increments.
  - If the new row_cnt equals the latched num_rows, go to IDLE and pulse frame_done in the same cycle as row_done.
  - Otherwise go to REQ.
- row_vld outside REQ: ignored, no state change.
- start in any state:
  - Latch num_rows, clear row_cnt and col_cnt, drop pix_vld.
  - Go to REQ, or to IDLE with a frame_done pulse next cycle if num_rows=0.
  - start takes priority over a coincident handshake or row_vld.
- num_rows>256 is saturated to 256.
- col_cnt wraps 255→0 only through a new row load; it never wraps inside a row.
- Reset mid-frame returns everything to reset values immediately (asynchronous).

## Timing
- start at cycle t: row_req=1 at t+1.
- row_vld at cycle r (in REQ): pix_vld=1 with column 0 at r+1; row_req=0 at r+1.
- Full-rate stream: with pix_rdy held high, one pixel per cycle. A row occupies 256 cycles of pix_vld plus ≥1 REQ cycle.
- row_done, frame_done, row_cnt update: all registered, visible in the cycle after the column-255 handshake. row_req (when more rows remain) also rises that cycle.
- Zero-bubble row-to-row transfer is not required: pix_vld is low for at least one cycle between rows.

## Structure
- Shared package coproc_pkg holds:
  - PIX_W, COLS, ROW_W constants
  - state enum {IDLE, REQ, STREAM}, also used by the accumulator-side bench
- One natural sub-module: row_shift_reg, a ROW_W load/shift register with ports load, shift, din, dout[PIX_W-1:0].
- FSM and counters live in data_disperse.

## Test plan
- Reset: assert rst_n=0 mid-stream.
  - Required: all outputs 0 immediately; busy=0.
- Single row, pix_rdy=1, num_rows=1, row_in column c = c+1:
  - pix_out sequence 1..256 with col_cnt 0..255 on consecutive cycles.
  - row_done and frame_done both pulse once, the cycle after column 255.
- Backpressure: pix_rdy toggled pseudo-randomly.
  - Every pixel delivered exactly once, in order.
  - pix_out stable while pix_vld=1 and pix_rdy=0.
- Multi-row: num_rows=3, each row's pixels = row index.
  - Three row_req phases.
  - row_cnt 0,1,2.
  - Three row_done pulses; frame_done only with the third.
- Edge cases:
  - num_rows=0: frame_done one cycle after start; row_req never asserted.
  - row_vld while in STREAM: ignored; stream unchanged.
- Abort: start asserted at column 100 of row 1 with num_rows=2.
  - pix_vld=0 next cycle.
  - row_cnt=0, col_cnt=0.
  - row_req=1; new frame streams normally.
